// File: rtl/coin_payer.sv
// coin_payer: customer-side driver for the cola vending interface.
// A buy request produces PRICE one-cycle coin pulses on po_money, spaced by
// GAP idle cycles, then waits up to TIMEOUT cycles for pi_cola.
// The result is reported as a one-cycle po_done or po_err pulse, and
// successful purchases are counted in a saturating 8-bit counter.
// Optional feature macro: COIN_PAYER_QUEUE_EN adds a single-entry pending
// request flag that captures a pi_buy arriving while busy.
// Handshake: po_money is a one-cycle strobe per coin with no back-pressure.
// pi_cola is honoured only in the final PAY cycle and in WAIT.
// pi_buy is a level sampled every rising edge, and it is acted on only in IDLE
// (or is queued, when the pending flag is built in).
module coin_payer #(
    parameter int PRICE   = 3,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pi_buy,
    input  logic       pi_cola,
    output logic       po_money,
    output logic       po_busy,
    output logic       po_done,
    output logic       po_err,
    output logic [7:0] po_cola_cnt,
    output logic [3:0] po_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_PAY  = 4'b0010,
        S_GAP  = 4'b0100,
        S_WAIT = 4'b1000
    } state_t;

    localparam logic [3:0] COIN_LAST = 4'(PRICE - 1);
    localparam logic [3:0] GAP_LAST  = 4'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] coin_cnt_q, coin_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] cola_cnt_q, cola_cnt_d;
    logic       start;

`ifdef COIN_PAYER_QUEUE_EN
    logic pend_q, pend_d;

    // Pending flag: remember one request seen while busy, drop it once consumed.
    always_comb begin
        pend_d = pend_q;
        if (state_q == S_IDLE) begin
            pend_d = 1'b0;
        end else if (pi_buy) begin
            pend_d = 1'b1;
        end
    end

    // Pending flag register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign start = pi_buy | pend_q;
`else
    assign start = pi_buy;
`endif

    // Next-state, counter and result logic for the payment sequence.
    always_comb begin
        state_d    = state_q;
        coin_cnt_d = coin_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        wait_cnt_d = wait_cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cola_cnt_d = cola_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_PAY;
                    coin_cnt_d = 4'd0;
                end
            end
            S_PAY: begin
                coin_cnt_d = coin_cnt_q + 4'd1;
                if (coin_cnt_q == COIN_LAST && pi_cola) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (coin_cnt_q == COIN_LAST) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd0;
                end else if (GAP == 0) begin
                    state_d = S_PAY;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = 4'd0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_PAY;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (pi_cola) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (done_d && cola_cnt_q != 8'hFF) begin
            cola_cnt_d = cola_cnt_q + 8'd1;
        end
    end

    // State, counters and registered result pulses; reset aborts everything.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            coin_cnt_q <= 4'd0;
            gap_cnt_q  <= 4'd0;
            wait_cnt_q <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cola_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            coin_cnt_q <= coin_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cola_cnt_q <= cola_cnt_d;
        end
    end

    assign po_money     = (state_q == S_PAY);
    assign po_busy      = (state_q != S_IDLE);
    assign po_done      = done_q;
    assign po_err       = err_q;
    assign po_cola_cnt  = cola_cnt_q;
    assign po_dbg_state = state_q;

endmodule

// File: tb/tb_coin_payer.sv
// tb_coin_payer: directed bench for coin_payer with default parameters.
// A small vending-machine model answers the coins in one of four modes.
// Mode 0 never acknowledges.
// Mode 1 acknowledges one cycle after the third coin.
// Mode 2 acknowledges combinationally during the third coin.
// Mode 3 holds pi_cola high all the time.
// Build with COIN_PAYER_QUEUE_EN to exercise the pending-request variant.
module tb_coin_payer;

    localparam int PRICE = 3;
    localparam int GAP   = 2;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       pi_buy;
    logic       pi_cola;
    logic       po_money;
    logic       po_busy;
    logic       po_done;
    logic       po_err;
    logic [7:0] po_cola_cnt;
    logic [3:0] po_dbg_state;

    int n_checks;
    int n_fail;
    int cola_mode;

    coin_payer dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pi_buy      (pi_buy),
        .pi_cola     (pi_cola),
        .po_money    (po_money),
        .po_busy     (po_busy),
        .po_done     (po_done),
        .po_err      (po_err),
        .po_cola_cnt (po_cola_cnt),
        .po_dbg_state(po_dbg_state)
    );

    // Clock: 10 ns period.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Vending machine model: counts coins, raises a registered ack after the third.
    logic [1:0] seen_q;
    logic       ack_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seen_q <= 2'd0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (po_done || po_err) begin
                seen_q <= 2'd0;
            end else if (po_money && seen_q != 2'd3) begin
                seen_q <= seen_q + 2'd1;
                if (seen_q == 2'd2 && cola_mode == 1) ack_q <= 1'b1;
            end
        end
    end

    // Acknowledge selection for the current mode.
    always_comb begin
        pi_cola = 1'b0;
        case (cola_mode)
            1: pi_cola = ack_q;
            2: pi_cola = po_money && (seen_q == 2'd2);
            3: pi_cola = 1'b1;
            default: pi_cola = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One purchase: pulse pi_buy, follow cycles N+1.. until done/err or budget.
    task automatic run_txn(input int mode, output int lat, output logic [63:0] mask,
                           output logic got_done, output logic got_err,
                           output logic busy_end, output logic busy_first);
        cola_mode = mode;
        lat = -1; mask = '0; got_done = 1'b0; got_err = 1'b0; busy_end = 1'b1;
        @(negedge sys_clk);
        pi_buy = 1'b1;
        @(posedge sys_clk);
        #1 pi_buy = 1'b0;
        busy_first = po_busy;
        for (int t = 1; t <= 40; t++) begin
            if (po_money) mask[t] = 1'b1;
            if (po_done || po_err) begin
                lat = t; got_done = po_done; got_err = po_err; busy_end = po_busy;
                break;
            end
            @(posedge sys_clk);
            #1;
        end
    endtask

    typedef struct {
        int         mode;
        logic       exp_done;
        logic       exp_err;
        int         exp_lat;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t        vecs[5];
    logic [63:0] exp_mask;
    int          lat;
    logic [63:0] mask;
    logic        got_done, got_err, busy_end, busy_first;
    int          coins, dones, done_t;
    logic        money_after, done_seen;

    initial begin
        n_checks = 0; n_fail = 0;
        cola_mode = 0;
        pi_buy = 1'b0;
        sys_rst_n = 1'b0;

        vecs[0] = '{mode: 1, exp_done: 1'b1, exp_err: 1'b0, exp_lat: 9,  exp_cnt: 8'd1};
        vecs[1] = '{mode: 0, exp_done: 1'b0, exp_err: 1'b1, exp_lat: 16, exp_cnt: 8'd1};
        vecs[2] = '{mode: 2, exp_done: 1'b1, exp_err: 1'b0, exp_lat: 8,  exp_cnt: 8'd2};
        vecs[3] = '{mode: 3, exp_done: 1'b1, exp_err: 1'b0, exp_lat: 8,  exp_cnt: 8'd3};
        vecs[4] = '{mode: 0, exp_done: 1'b0, exp_err: 1'b1, exp_lat: 16, exp_cnt: 8'd3};

        exp_mask = '0;
        for (int k = 0; k < PRICE; k++) exp_mask[1 + k * (GAP + 1)] = 1'b1;

        // Reset held for 40 ns; outputs must all be low.
        #40;
        check("reset_money", {31'd0, po_money}, 32'd0);
        check("reset_busy",  {31'd0, po_busy},  32'd0);
        check("reset_done",  {31'd0, po_done},  32'd0);
        check("reset_err",   {31'd0, po_err},   32'd0);
        check("reset_cnt",   {24'd0, po_cola_cnt}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Table-driven purchases.
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].mode, lat, mask, got_done, got_err, busy_end, busy_first);
            check($sformatf("v%0d_busy_first", i), {31'd0, busy_first}, 32'd1);
            check($sformatf("v%0d_coin_lo", i), mask[31:0], exp_mask[31:0]);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_done", i), {31'd0, got_done}, {31'd0, vecs[i].exp_done});
            check($sformatf("v%0d_err", i), {31'd0, got_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_busy_end", i), {31'd0, busy_end}, 32'd0);
            check($sformatf("v%0d_cnt", i), {24'd0, po_cola_cnt}, {24'd0, vecs[i].exp_cnt});
            @(posedge sys_clk);
            #1;
            check($sformatf("v%0d_pulse_once", i), {31'd0, po_done | po_err}, 32'd0);
        end

        // Reset between coin 2 and coin 3 aborts everything immediately.
        cola_mode = 1;
        @(negedge sys_clk);
        pi_buy = 1'b1;
        @(posedge sys_clk);
        #1 pi_buy = 1'b0;
        for (int t = 1; t < 5; t++) begin
            @(posedge sys_clk);
            #1;
        end
        check("mid_busy_before", {31'd0, po_busy}, 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_money", {31'd0, po_money}, 32'd0);
        check("mid_rst_busy",  {31'd0, po_busy},  32'd0);
        check("mid_rst_done",  {31'd0, po_done},  32'd0);
        check("mid_rst_err",   {31'd0, po_err},   32'd0);
        check("mid_rst_cnt",   {24'd0, po_cola_cnt}, 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_txn(1, lat, mask, got_done, got_err, busy_end, busy_first);
        check("post_rst_coins", mask[31:0], exp_mask[31:0]);
        check("post_rst_lat", lat, 9);
        check("post_rst_done", {31'd0, got_done}, 32'd1);
        check("post_rst_cnt", {24'd0, po_cola_cnt}, 32'd1);

        // Request while busy: queued with the pending flag, dropped without.
        cola_mode = 1;
        coins = 0; dones = 0; done_t = -1; money_after = 1'b0; done_seen = 1'b0;
        @(negedge sys_clk);
        pi_buy = 1'b1;
        @(posedge sys_clk);
        #1 pi_buy = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            if (t == 3) pi_buy = 1'b1;
            if (t == 4) pi_buy = 1'b0;
            if (po_money) coins++;
            if (done_seen && t == done_t + 1) money_after = po_money;
            if (po_done) begin
                dones++;
                if (!done_seen) begin
                    done_seen = 1'b1;
                    done_t = t;
                end
            end
            @(posedge sys_clk);
            #1;
        end
        check("q_first_done_t", done_t, 9);
`ifdef COIN_PAYER_QUEUE_EN
        check("q_money_after_done", {31'd0, money_after}, 32'd1);
        check("q_coins", coins, 6);
        check("q_dones", dones, 2);
        check("q_cnt", {24'd0, po_cola_cnt}, 32'd3);
`else
        check("q_money_after_done", {31'd0, money_after}, 32'd0);
        check("q_coins", coins, 3);
        check("q_dones", dones, 1);
        check("q_cnt", {24'd0, po_cola_cnt}, 32'd2);
`endif

        // 260 back-to-back purchases saturate the counter at 255.
        for (int i = 0; i < 260; i++) begin
            run_txn(2, lat, mask, got_done, got_err, busy_end, busy_first);
        end
        check("sat_last_done", {31'd0, got_done}, 32'd1);
        check("sat_last_lat", lat, 8);
        check("sat_cnt", {24'd0, po_cola_cnt}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
